// File: rtl/clk_div_pkg.sv
// clk_div_gen shared types and defaults.
// Run-state encoding and default channel/counter sizing.
package clk_div_pkg;

  localparam int CNT_W_DEF  = 16;
  localparam int NUM_CH_DEF = 3;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } run_state_t;

endpackage

// File: rtl/clk_div_chan.sv
// One programmable tick / square-wave channel of clk_div_gen.
// Divisor is shadowed and only reloaded at period boundaries.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             start,
  input  logic [CNT_W-1:0] div,
  output logic             tick,
  output logic             wave
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] div_sh;
  logic [CNT_W-1:0] last;

  assign last = div_sh - CNT_W'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt    <= '0;
      div_sh <= '0;
      tick   <= 1'b0;
      wave   <= 1'b0;
    end else if (start) begin
      cnt    <= '0;
      div_sh <= div;
      tick   <= 1'b0;
      wave   <= 1'b0;
    end else if (!run) begin
      cnt    <= '0;
      tick   <= 1'b0;
      wave   <= 1'b0;
    end else if (div_sh == '0) begin
      // parked: keep sampling until a nonzero divisor shows up
      cnt    <= '0;
      div_sh <= div;
      tick   <= 1'b0;
      wave   <= 1'b0;
    end else if (cnt == last) begin
      cnt    <= '0;
      div_sh <= div;
      tick   <= 1'b1;
      wave   <= ~wave;
    end else begin
      cnt    <= cnt + CNT_W'(1);
      tick   <= 1'b0;
    end
  end

endmodule

// File: rtl/clk_div_gen.sv
// Multi-channel clock-enable generator with shared run/stop alignment.
// Define CLK_DIV_GEN_SYNC_EN to pass sc through a 2-flop synchronizer.
module clk_div_gen
  import clk_div_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    sc,
  input  logic [NUM_CH*CNT_W-1:0] div_i,
  output logic [NUM_CH-1:0]       tick_o,
  output logic [NUM_CH-1:0]       clk_o,
  output logic                    run_o
);

  logic       sc_s;
  logic       start;
  logic       run;
  run_state_t state;
  run_state_t state_nx;

`ifdef CLK_DIV_GEN_SYNC_EN
  logic [1:0] sc_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sc_q <= '0;
    end else begin
      sc_q <= {sc_q[0], sc};
    end
  end

  assign sc_s = sc_q[1];
`else
  assign sc_s = sc;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      run_o <= 1'b0;
    end else begin
      state <= state_nx;
      run_o <= (state_nx == RUN);
    end
  end

  always_comb begin
    state_nx = state;
    start    = 1'b0;
    run      = 1'b0;
    unique case (1'b1)
      (state == IDLE): begin
        if (sc_s) begin
          state_nx = RUN;
          start    = 1'b1;
        end
      end
      (state == RUN): begin
        if (sc_s) begin
          run = 1'b1;
        end else begin
          state_nx = IDLE;
        end
      end
    endcase
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    clk_div_chan #(
      .CNT_W(CNT_W)
    ) u_chan (
      .clk  (clk),
      .rst_n(rst_n),
      .run  (run),
      .start(start),
      .div  (div_i[k*CNT_W +: CNT_W]),
      .tick (tick_o[k]),
      .wave (clk_o[k])
    );
  end

endmodule

// File: tb/tb_clk_div_gen.sv
// Directed self-checking bench for clk_div_gen.
// Expected tick/wave patterns are derived from divisor arithmetic.
module tb_clk_div_gen;

`ifdef CLK_DIV_GEN_SYNC_EN
  localparam int SL = 2;
`else
  localparam int SL = 0;
`endif

  logic        clk;
  logic        rst_n;
  logic        sc;
  logic [47:0] div_i;
  logic [2:0]  tick_o;
  logic [2:0]  clk_o;
  logic        run_o;

  int vectors;
  int miscompares;

  clk_div_gen #(
    .NUM_CH(3),
    .CNT_W (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sc    (sc),
    .div_i (div_i),
    .tick_o(tick_o),
    .clk_o (clk_o),
    .run_o (run_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // n = edges since the start edge (n >= 1)
  function automatic void exp3(input int n, input int d0, input int d1,
                               input int d2, output logic [2:0] t,
                               output logic [2:0] c);
    int d[3];
    d = '{d0, d1, d2};
    for (int k = 0; k < 3; k++) begin
      if (d[k] == 0) begin
        t[k] = 1'b0;
        c[k] = 1'b0;
      end else begin
        t[k] = (n % d[k] == 0);
        c[k] = ((n / d[k]) % 2 == 1);
      end
    end
  endfunction

  task automatic start_run(input logic [47:0] d);
    sc = 1'b0;
    repeat (SL + 1) step();
    div_i = d;
    sc = 1'b1;
    repeat (SL + 1) step();
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    sc    = 1'b1;
    div_i = {16'd4, 16'd4, 16'd4};
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if ({run_o, clk_o, tick_o} !== 7'b0) begin
        miscompares++;
        $display("FAIL reset cyc%0d run/clk/tick=%b req 0000000", i,
                 {run_o, clk_o, tick_o});
      end
    end
    rst_n = 1'b1;
    for (int i = 0; i < SL; i++) begin
      step();
      vectors++;
      if (run_o !== 1'b0) begin
        miscompares++;
        $display("FAIL release_sync run_o=%b req 0", run_o);
      end
    end
    step();
    vectors++;
    if (run_o !== 1'b1) begin
      miscompares++;
      $display("FAIL release run_o=%b req 1", run_o);
    end
    sc = 1'b0;
    repeat (SL + 1) step();
    vectors++;
    if ({run_o, clk_o, tick_o} !== 7'b0) begin
      miscompares++;
      $display("FAIL stop_idle run/clk/tick=%b req 0000000",
               {run_o, clk_o, tick_o});
    end
  endtask

  task automatic test_basic;
    logic [2:0] et;
    logic [2:0] ec;
    start_run({16'd2, 16'd3, 16'd5});
    for (int n = 1; n <= 30; n++) begin
      step();
      exp3(n, 5, 3, 2, et, ec);
      vectors++;
      if (tick_o !== et || clk_o !== ec || run_o !== 1'b1) begin
        miscompares++;
        $display("FAIL basic n=%0d tick=%b req %b clk=%b req %b run=%b",
                 n, tick_o, et, clk_o, ec, run_o);
      end
    end
  endtask

  task automatic test_reload;
    logic [2:0] et;
    logic [2:0] ec;
    start_run({16'd0, 16'd0, 16'd8});
    for (int n = 1; n <= 15; n++) begin
      step();
      et = {2'b00, (n == 8 || n == 11 || n == 14)};
      ec = {2'b00, ((n >= 8 && n < 11) || n >= 14)};
      vectors++;
      if (tick_o !== et || clk_o !== ec) begin
        miscompares++;
        $display("FAIL reload n=%0d tick=%b req %b clk=%b req %b",
                 n, tick_o, et, clk_o, ec);
      end
      if (n == 2) div_i[15:0] = 16'd3;
    end
  endtask

  task automatic test_edge;
    logic [2:0] et;
    logic [2:0] ec;
    int m;
    start_run({16'd0, 16'd0, 16'd1});
    for (int n = 1; n <= 16; n++) begin
      step();
      m = n - 6;
      et[0] = 1'b1;
      ec[0] = (n % 2 == 1);
      et[1] = (m >= 5) && ((m - 1) % 4 == 0);
      ec[1] = (m >= 5) && (((m - 1) / 4) % 2 == 1);
      et[2] = 1'b0;
      ec[2] = 1'b0;
      vectors++;
      if (tick_o !== et || clk_o !== ec) begin
        miscompares++;
        $display("FAIL edge_div n=%0d tick=%b req %b clk=%b req %b",
                 n, tick_o, et, clk_o, ec);
      end
      if (n == 6) div_i[31:16] = 16'd4;
    end
  endtask

  task automatic test_stop_restart;
    logic [2:0] et;
    logic [2:0] ec;
    start_run({16'd2, 16'd3, 16'd5});
    repeat (7) step();
    sc = 1'b0;
    step();
    sc = 1'b1;
    repeat (SL) step();
    vectors++;
    if ({run_o, clk_o, tick_o} !== 7'b0) begin
      miscompares++;
      $display("FAIL stop_pulse run/clk/tick=%b req 0000000",
               {run_o, clk_o, tick_o});
    end
    step();
    for (int n = 1; n <= 12; n++) begin
      step();
      exp3(n, 5, 3, 2, et, ec);
      vectors++;
      if (tick_o !== et || clk_o !== ec || run_o !== 1'b1) begin
        miscompares++;
        $display("FAIL realign n=%0d tick=%b req %b clk=%b req %b",
                 n, tick_o, et, clk_o, ec);
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [2:0] et;
    logic [2:0] ec;
    start_run({16'd2, 16'd3, 16'd5});
    repeat (6) step();
    rst_n = 1'b0;
    step();
    vectors++;
    if ({run_o, clk_o, tick_o} !== 7'b0) begin
      miscompares++;
      $display("FAIL reset_mid run/clk/tick=%b req 0000000",
               {run_o, clk_o, tick_o});
    end
    rst_n = 1'b1;
    repeat (SL + 1) step();
    for (int n = 1; n <= 10; n++) begin
      step();
      exp3(n, 5, 3, 2, et, ec);
      vectors++;
      if (tick_o !== et || clk_o !== ec) begin
        miscompares++;
        $display("FAIL after_reset n=%0d tick=%b req %b clk=%b req %b",
                 n, tick_o, et, clk_o, ec);
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    sc          = 1'b0;
    div_i       = '0;
    #1;
    test_reset();
    test_basic();
    test_reload();
    test_edge();
    test_stop_restart();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors,
             miscompares);
    $finish;
  end

endmodule
